// File: rtl/channel_decimator.sv
// Accumulate-and-dump decimator with normalising shift, saturation and an output FIFO.
// One cycle from dump to valid_out; no input backpressure, so results are dropped (overflow) when the FIFO is full.
module channel_decimator #(
  parameter int DATA_WIDTH = 32,
  parameter int DECIM_MAX  = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + $clog2(DECIM_MAX),
  parameter int FIFO_DEPTH = 4,
  localparam int CW = $clog2(DECIM_MAX) + 1,
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  input  logic                  enable,
  input  logic [CW-1:0]         decim_ratio,
  input  logic [CW-1:0]         norm_shift,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [LW-1:0]         fifo_level,
  output logic                  overflow,
  input  logic                  clear_ovf,
  output logic [15:0]           frames_out
);

  localparam int SMAX = $clog2(DECIM_MAX);
  localparam int AW   = $clog2(FIFO_DEPTH);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                state, state_nxt;
  logic [ACC_WIDTH-1:0]  acc, acc_nxt, sum, shifted;
  logic [CW-1:0]         count, count_nxt;
  logic [CW-1:0]         r_lat, s_lat, r_req, s_req, r_cur, s_cur;
  logic                  take, dump;
  logic [DATA_WIDTH-1:0] result;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [LW-1:0]         level;
  logic                  full, push, pop, drop;

  // Ratio/shift for the current sample: freshly clamped at frame start, latched otherwise.
  always_comb begin
    if (decim_ratio == '0)                 r_req = CW'(1);
    else if (decim_ratio > CW'(DECIM_MAX)) r_req = CW'(DECIM_MAX);
    else                                   r_req = decim_ratio;
    s_req   = (norm_shift > CW'(SMAX)) ? CW'(SMAX) : norm_shift;
    r_cur   = (count == '0) ? r_req : r_lat;
    s_cur   = (count == '0) ? s_req : s_lat;
    sum     = acc + {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, data_in};
    shifted = sum >> s_cur;
    result  = (shifted[ACC_WIDTH-1:DATA_WIDTH] != '0) ? '1 : shifted[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    take      = 1'b0;
    dump      = 1'b0;
    case (state)
      IDLE: begin
        acc_nxt   = '0;
        count_nxt = '0;
        if (enable) begin
          state_nxt = ACCUM;
          take      = 1'b1;
        end
      end
      ACCUM: begin
        if (!enable) begin
          state_nxt = IDLE;
          acc_nxt   = '0;
          count_nxt = '0;
        end else begin
          take = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take && valid_in) begin
      if (count + CW'(1) == r_cur) begin
        dump      = 1'b1;
        acc_nxt   = '0;
        count_nxt = '0;
      end else begin
        acc_nxt   = sum;
        count_nxt = count + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      acc   <= '0;
      count <= '0;
      r_lat <= CW'(1);
      s_lat <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      count <= count_nxt;
      if (take && valid_in && count == '0) begin
        r_lat <= r_req;
        s_lat <= s_req;
      end
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign valid_out  = (level != '0);
  assign full       = (level == LW'(FIFO_DEPTH));
  assign pop        = valid_out && ready_in;
  assign push       = dump && (!full || pop);
  assign drop       = dump && full && !pop;
  assign data_out   = valid_out ? mem[rd_ptr] : '0;
  assign fifo_level = level;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      frames_out <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
      if (clear_ovf)  overflow <= 1'b0;
      else if (drop)  overflow <= 1'b1;
      if (push) frames_out <= frames_out + 16'd1;
    end
  end

endmodule

// File: tb/tb_channel_decimator.sv
// Directed bench for channel_decimator: hand-computed vectors, immediate assertions per comparison.
module tb_channel_decimator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        valid_in;
  logic        enable;
  logic [4:0]  decim_ratio;
  logic [4:0]  norm_shift;
  logic [31:0] data_out;
  logic        valid_out;
  logic        ready_in;
  logic [2:0]  fifo_level;
  logic        overflow;
  logic        clear_ovf;
  logic [15:0] frames_out;

  int n_checks = 0;
  int n_fail   = 0;

  channel_decimator dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
    .enable(enable), .decim_ratio(decim_ratio), .norm_shift(norm_shift),
    .data_out(data_out), .valid_out(valid_out), .ready_in(ready_in),
    .fifo_level(fifo_level), .overflow(overflow), .clear_ovf(clear_ovf),
    .frames_out(frames_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input logic [31:0] d);
    valid_in = 1'b1;
    data_in  = d;
    tick();
  endtask

  task automatic idle();
    valid_in = 1'b0;
    data_in  = '0;
    tick();
  endtask

  initial begin
    rst_n = 1'b0; data_in = '0; valid_in = 1'b0; enable = 1'b0;
    decim_ratio = '0; norm_shift = '0; ready_in = 1'b0; clear_ovf = 1'b0;
    #12;
    check("rst_valid", valid_out, 0);
    check("rst_data", data_out, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_frames", frames_out, 0);
    rst_n = 1'b1;

    // R=4, S=2: (10+20+30+40)>>2 = 25
    enable = 1'b1; decim_ratio = 5'd4; norm_shift = 5'd2; ready_in = 1'b1;
    samp(10); samp(20); samp(30);
    check("r4_no_early", valid_out, 0);
    samp(40);
    check("r4_valid", valid_out, 1);
    check("r4_data", data_out, 25);
    check("r4_frames", frames_out, 1);
    idle();
    check("r4_popped", valid_out, 0);

    // R=0 treated as 1
    decim_ratio = 5'd0; norm_shift = 5'd0;
    samp(7);
    check("r0_first", data_out, 7);
    samp(9);
    check("r0_second", data_out, 9);
    check("r0_level", fifo_level, 1);
    idle();

    // Saturation
    decim_ratio = 5'd2;
    samp(32'hFFFF_FFFF); samp(32'hFFFF_FFFF);
    check("sat_data", data_out, 32'hFFFF_FFFF);
    check("sat_frames", frames_out, 4);
    idle();

    // Fill with ready_in=0, drop 5 and 6
    ready_in = 1'b0; decim_ratio = 5'd1;
    samp(1); samp(2); samp(3); samp(4);
    check("fill_level4", fifo_level, 4);
    check("fill_no_ovf", overflow, 0);
    samp(5); samp(6);
    check("full_level", fifo_level, 4);
    check("full_ovf", overflow, 1);
    check("full_frames", frames_out, 8);
    check("full_head", data_out, 1);

    // clear_ovf beats a drop in the same cycle
    clear_ovf = 1'b1;
    samp(7);
    clear_ovf = 1'b0;
    check("clr_prio_ovf", overflow, 0);
    check("clr_prio_frames", frames_out, 8);

    // Push and pop together on a full FIFO
    ready_in = 1'b1;
    samp(5);
    check("pp_level", fifo_level, 4);
    check("pp_ovf", overflow, 0);
    check("pp_frames", frames_out, 9);
    check("pp_head2", data_out, 2);
    idle();
    check("drain3", data_out, 3);
    idle();
    check("drain4", data_out, 4);
    idle();
    check("drain5", data_out, 5);
    idle();
    check("drain_empty", valid_out, 0);

    // Partial frame discarded by enable=0
    decim_ratio = 5'd4; norm_shift = 5'd2;
    samp(100); samp(100);
    enable = 1'b0;
    samp(100);
    enable = 1'b1;
    samp(8); samp(8); samp(8);
    check("abort_no_out", valid_out, 0);
    samp(8);
    check("abort_data", data_out, 8);
    check("abort_frames", frames_out, 10);
    idle();

    // Mid-frame ratio change applies next frame
    decim_ratio = 5'd2; norm_shift = 5'd0;
    samp(3);
    decim_ratio = 5'd4;
    samp(5);
    check("midchg_data", data_out, 8);
    samp(1); samp(1); samp(1);
    check("midchg_wait", valid_out, 0);
    samp(1);
    check("midchg_r4", data_out, 4);
    idle();

    // Shift clamps to 4
    decim_ratio = 5'd1; norm_shift = 5'd31;
    samp(32'h100);
    check("shift_clamp", data_out, 32'h10);
    idle();

    // Ratio clamps to 16
    decim_ratio = 5'd31; norm_shift = 5'd0;
    for (int i = 0; i < 15; i++) samp(1);
    check("ratio_clamp_wait", valid_out, 0);
    samp(1);
    check("ratio_clamp_data", data_out, 16);
    check("ratio_clamp_frames", frames_out, 14);
    idle();

    // Asynchronous reset mid-frame with a non-empty FIFO
    ready_in = 1'b0; decim_ratio = 5'd1;
    samp(5);
    check("pre_rst_valid", valid_out, 1);
    decim_ratio = 5'd4;
    samp(2);
    valid_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", valid_out, 0);
    check("arst_data", data_out, 0);
    check("arst_level", fifo_level, 0);
    check("arst_frames", frames_out, 0);
    #2 rst_n = 1'b1;
    ready_in = 1'b1; decim_ratio = 5'd2;
    samp(3); samp(4);
    check("post_rst_data", data_out, 7);
    check("post_rst_frames", frames_out, 1);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_decimator.md
Name: channel_decimator

Overview:
- Downstream stage of the per-channel processor. Consumes the processor's `data_out`/`valid_out` sample stream.
- Integrates samples in an accumulate-and-dump decimator with a programmable ratio and normalising right shift.
- Saturates results to DATA_WIDTH and delivers them through a small output FIFO with a valid/ready handshake toward the mixer/output stage.
- The upstream processor has no backpressure, so this FIFO absorbs downstream stalls. Lost results are flagged.

Parameters:
- DATA_WIDTH, 32, sample width in and out (unsigned).
- DECIM_MAX, 16, largest supported decimation ratio (power of two).
- ACC_WIDTH, DATA_WIDTH+$clog2(DECIM_MAX), accumulator width. Never overflows at DECIM_MAX.
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  DATA_WIDTH  sample from channel processor, unsigned.
- valid_in  input  1  data_in qualifier. One sample per high cycle, no ready.
- enable  input  1  decimator run control.
- decim_ratio  input  $clog2(DECIM_MAX)+1  samples per output. 0 is treated as 1; values >DECIM_MAX clamp to DECIM_MAX.
- norm_shift  input  $clog2(DECIM_MAX)+1  right shift applied to the sum before saturation.
- data_out  output  DATA_WIDTH  FIFO head.
- valid_out  output  1  FIFO non-empty.
- ready_in  input  1  downstream accept. Pop occurs when valid_out && ready_in.
- fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky: a result was dropped on a full FIFO.
- clear_ovf  input  1  synchronous pulse that clears overflow.
- frames_out  output  16  count of results pushed into the FIFO. Wraps 0xFFFF->0.

Behaviour:

Reset (rst_n low, asynchronous):
- acc=0, sample count=0, state IDLE.
- FIFO emptied: data_out=0, valid_out=0, fifo_level=0.
- overflow=0, frames_out=0.

State machine:
- IDLE: accumulator and count held at 0; valid_in ignored.
  - IDLE->ACCUM on the first cycle enable=1.
  - That cycle's valid_in sample IS accumulated.
- ACCUM: on each valid_in=1, acc += data_in and count += 1.
  - ACCUM->IDLE whenever enable=0. The partial accumulator and count are discarded and no result is produced.
  - FIFO contents, the output handshake, overflow and frames_out are unaffected by enable.

Ratio and shift latching:
- Effective ratio R and shift S are latched when count==0 and a valid sample arrives, i.e. at frame start.
- Changes mid-frame take effect at the next frame.
- S > $clog2(DECIM_MAX) clamps to $clog2(DECIM_MAX).

Dump:
- Occurs on the valid sample that makes count==R.
- result = (acc + data_in) >> S, unsigned. If result > 2^DATA_WIDTH-1, result = 2^DATA_WIDTH-1.
- acc<=0, count<=0. The next valid sample starts a new frame (no dead cycle).
- R=1: every valid sample is dumped individually as data_in>>S.

FIFO push/pop:
- Each dump is a push request; frames_out increments on every accepted push.
- Push accepted at cycle N appears in the FIFO at N+1. If the FIFO was empty, valid_out=1 and data_out=result at N+1.
- Results are delivered in order. data_out is stable while valid_out=1 and ready_in=0.
- Push when full and no pop in the same cycle: the result is dropped, overflow<=1, frames_out unchanged.
- Push and pop in the same cycle when full: both succeed, level unchanged, no overflow.
- Push and pop in the same cycle when level==1: the new result becomes head at N+1, valid_out stays 1.
- Pop when empty: impossible because valid_out=0. ready_in is a don't-care then.

overflow:
- clear_ovf has priority over a set in the same cycle: overflow reads 0 next cycle.
- A drop in a later cycle sets it again.

fifo_level always equals pushes minus pops since reset.

Test Plan:
- Reset then enable=1, R=4, S=2, ready_in=1, samples 10,20,30,40 on consecutive cycles -> one result 25 with valid_out high the cycle after the 40 sample; frames_out=1.
- R=0, S=0, samples 7,9 -> outputs 7 then 9 (ratio treated as 1), one cycle latency each.
- R=2, S=0, samples 0xFFFFFFFF,0xFFFFFFFF -> output saturates to 0xFFFFFFFF.
- ready_in=0, R=1, 6 samples 1..6 -> FIFO holds 1,2,3,4, fifo_level=4, overflow=1, frames_out=4. Then ready_in=1 -> pops 1,2,3,4 in order. clear_ovf -> overflow=0.
- Full FIFO with ready_in=1 and a push in the same cycle -> no drop, level stays 4, overflow stays 0.
- R=4, 2 samples then enable=0 for one cycle then enable=1 and 4 samples of 8 with S=2 -> single output 8, partial frame discarded; change decim_ratio mid-frame -> applies only from the next frame. Assert rst_n low mid-frame -> all outputs return to reset values asynchronously.
